// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the 4x4 matrix keypad scanner:
//   - state_e   : scanner FSM states
//   - KEY_MAP   : hex code per key, indexed by {row, column}
//   - KEY_CLR / KEY_DEL : codes that edit the digit buffer instead of entering
//   - single_low / low_index : helpers for decoding the active-low row bus
// -----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_e;

    localparam logic [3:0] KEY_CLR = 4'hF;  // '#'
    localparam logic [3:0] KEY_DEL = 4'hE;  // '*'

    // Index = row*4 + column.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // True when exactly one active-low row line is asserted.
    function automatic logic single_low(input logic [3:0] r);
        return ($countones(~r) == 1);
    endfunction

    // Index of the (single) low row line.
    function automatic logic [1:0] low_index(input logic [3:0] r);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!r[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for the asynchronous keypad row lines. Resets to all
// ones, matching the idle (pulled-up) state of the rows.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input bus
//   q_o    : synchronized output bus
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Scans a 4x4 active-low matrix keypad, debounces presses and releases on a
// slow scan tick, and reports each accepted key as a hex code.
//
// Parameters:
//   SCAN_DIV     : clock cycles per scan tick minus one
//   DEBOUNCE_CNT : stable ticks needed to accept a press or release (>= 1)
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   row[3:0]  in   keypad rows, active low, pulled up externally
//   col[3:0]  out  column drive, active low, one column at a time
//   key_code  out  hex code of the last accepted key
//   key_valid out  one-cycle pulse per accepted press
//   key_held  out  high while a key is pressed or its release is debouncing
//   digito    out  four-nibble entry buffer for the 7-segment driver
//
// Build option: define KEYPAD_DIGITS_EN to enable the digito entry buffer;
// otherwise digito is tied to zero.
// -----------------------------------------------------------------------------
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 3000,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digito
);

    localparam int unsigned DIV_W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       row_s;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    state_e           state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [DB_W-1:0]  dcnt_q, dcnt_d;
    logic [DB_W-1:0]  dcnt_inc;
    logic [3:0]       col_q;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       row_pat;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (row),
        .q_o    (row_s)
    );

    // Free-running scan tick divider.
    assign tick = (div_q == DIV_W'(SCAN_DIV));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    // Row pattern expected while the latched key stays down.
    assign row_pat  = ~(4'b0001 << row_idx_q);
    assign dcnt_inc = dcnt_q + DB_W'(1);

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_idx_d   = row_idx_q;
        dcnt_d      = dcnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    // Two or more low rows are ambiguous and treated as idle.
                    if (single_low(row_s)) begin
                        row_idx_d = low_index(row_s);
                        dcnt_d    = '0;
                        state_d   = ST_DEBOUNCE;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s == row_pat) begin
                        if (dcnt_inc >= DB_LAST) begin
                            state_d     = ST_PRESSED;
                            key_code_d  = KEY_MAP[{row_idx_q, col_idx_q}];
                            key_valid_d = 1'b1;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_PRESSED: begin
                    if (row_s[row_idx_q]) begin
                        state_d = ST_RELEASE;
                        dcnt_d  = '0;
                    end
                end
                ST_RELEASE: begin
                    if (row_s[row_idx_q]) begin
                        if (dcnt_inc >= DB_LAST) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end else begin
                        // Bounce during release: back to held, no new pulse.
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= '0;
            row_idx_q   <= '0;
            dcnt_q      <= '0;
            col_q       <= '1;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            dcnt_q      <= dcnt_d;
            col_q       <= ~(4'b0001 << col_idx_d);
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);

`ifdef KEYPAD_DIGITS_EN
    logic [15:0] digito_q, digito_d;

    // Updated on the same edge as key_code so both appear with key_valid.
    always_comb begin
        digito_d = digito_q;
        if (key_valid_d) begin
            if (key_code_d == KEY_CLR) begin
                digito_d = '0;
            end else if (key_code_d == KEY_DEL) begin
                digito_d = {4'h0, digito_q[15:4]};
            end else begin
                digito_d = {digito_q[11:0], key_code_d};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digito_q <= '0;
        end else begin
            digito_q <= digito_d;
        end
    end

    assign digito = digito_q;
`else
    assign digito = '0;
`endif

endmodule
